// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multiply/divide unit with HI/LO registers and a cancelable multi-cycle run.
// Optional multiply-accumulate ops (9-12) are enabled with `define MDU_MADD_EN.
module mul_div_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             cancel,
  output logic             busy,
  output logic             real_busy,
  output logic [WIDTH-1:0] mdu_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;
  logic             latch;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               div_signed, neg_a, neg_b;
  logic [WIDTH-1:0]   num, den, den_safe, uq, ur, quo, rem;

  function automatic logic is_mdu(input logic [3:0] o);
    logic r;
    r = (o >= OP_MULT) && (o <= OP_DIVU);
`ifdef MDU_MADD_EN
    r = r | ((o >= OP_MADD) && (o <= OP_MSUBU));
`endif
    return r;
  endfunction

  // Signed division runs on magnitudes; MIN_INT/-1 falls out as MIN_INT rem 0.
  always_comb begin
    prod_u     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    prod_s     = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    div_signed = (op_q == OP_DIV);
    neg_a      = div_signed & a_q[WIDTH-1];
    neg_b      = div_signed & b_q[WIDTH-1];
    num        = neg_a ? -a_q : a_q;
    den        = neg_b ? -b_q : b_q;
    den_safe   = (den == '0) ? WIDTH'(1) : den;
    uq         = num / den_safe;
    ur         = num % den_safe;
    quo        = (neg_a ^ neg_b) ? -uq : uq;
    rem        = neg_a ? -ur : ur;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          if (is_mdu(op)) begin
            state_d = RUN;
            latch   = 1'b1;
            cnt_d   = (op == OP_DIV || op == OP_DIVU) ? DIV_CNT : MUL_CNT;
          end else if (op == OP_MTHI) begin
            hi_d = d1;
          end else if (op == OP_MTLO) begin
            lo_d = d1;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
              if (b_q != '0) begin
                lo_d = quo;
                hi_d = rem;
              end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
            OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (latch) begin
        op_q <= op;
        a_q  <= d1;
        b_q  <= d2;
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign real_busy = busy | (start & is_mdu(op));
  assign mdu_out   = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed and randomized checks of mul_div_unit against a behavioural HI/LO model.
module tb_mul_div_unit;
  localparam int W = 32;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] d1 = '0, d2 = '0;
  logic         cancel = 1'b0;
  logic         busy, real_busy;
  logic [W-1:0] mdu_out;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] hi_m = '0, lo_m = '0;

  mul_div_unit #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
    .cancel(cancel), .busy(busy), .real_busy(real_busy), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mdu_op(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd4) || (MADD && o >= 4'd9 && o <= 4'd12);
  endfunction

  task automatic model_update(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sp  = sa * sb;
    up  = {32'b0, a} * {32'b0, b};
    acc = {hi_m, lo_m};
    case (o)
      4'd1: {hi_m, lo_m} = sp;
      4'd2: {hi_m, lo_m} = up;
      4'd3: if (b != 0) begin
        sq = sa / sb; sr = sa % sb;
        lo_m = sq[31:0]; hi_m = sr[31:0];
      end
      4'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      4'd7: hi_m = a;
      4'd8: lo_m = a;
      4'd9:  if (MADD) {hi_m, lo_m} = acc + sp;
      4'd10: if (MADD) {hi_m, lo_m} = acc + up;
      4'd11: if (MADD) {hi_m, lo_m} = acc - sp;
      4'd12: if (MADD) {hi_m, lo_m} = acc - up;
      default: ;
    endcase
  endtask

  // Issues one op and measures how long busy stays high; caller is #1 after an edge or at time 0.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    int lat;
    lat = (o == 4'd3 || o == 4'd4) ? 10 : 5;
    @(negedge clk);
    start = 1'b1; op = o; d1 = a; d2 = b;
    #1;
    check($sformatf("real_busy op%0d", o), real_busy, is_mdu_op(o));
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0; d1 = $urandom; d2 = $urandom;
    cyc = 0;
    while (busy && cyc < 50) begin
      cyc++;
      @(posedge clk); #1;
    end
    check($sformatf("busy_len op%0d", o), cyc, is_mdu_op(o) ? lat : 0);
    model_update(o, a, b);
  endtask

  task automatic read_check(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
    start = 1'b1; op = 4'd5; #1;
    check({tag, " hi"}, mdu_out, eh);
    op = 4'd6; #1;
    check({tag, " lo"}, mdu_out, el);
    start = 1'b0; op = 4'd0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] ops [12];
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd0, 4'd5};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset real_busy", real_busy, 1'b0);
    check("reset mdu_out none", mdu_out, 32'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    read_check("after reset", 32'h0, 32'h0);

    // DIVU 100/7 cancelled in its fourth busy cycle
    @(negedge clk);
    start = 1'b1; op = 4'd4; d1 = 32'd100; d2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    check("cancel busy rises", busy, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel busy falls", busy, 1'b0);
    read_check("after cancel", 32'h0, 32'h0);

    // start squashed by same-cycle cancel
    @(negedge clk);
    start = 1'b1; op = 4'd1; d1 = 32'd9; d2 = 32'd9; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0; cancel = 1'b0;
    check("squashed start busy", busy, 1'b0);

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
    read_check("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    read_check("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(4'd4, 32'd7, 32'd0);
    read_check("divu by zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    read_check("min/-1", 32'h0, 32'h8000_0000);
    run_op(4'd7, 32'h1234, 32'h0);
    read_check("mthi", 32'h1234, 32'h8000_0000);

    // MULTU 5*6 interrupted by reset in its second busy cycle
    @(negedge clk);
    start = 1'b1; op = 4'd2; d1 = 32'd5; d2 = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    check("reset mid busy", busy, 1'b0);
    check("reset mid real_busy", real_busy, 1'b0);
    read_check("reset mid", 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    hi_m = '0; lo_m = '0;

`ifdef MDU_MADD_EN
    run_op(4'd8, 32'd10, 32'd0);
    run_op(4'd7, 32'd0, 32'd0);
    run_op(4'd9, 32'd3, 32'd4);
    read_check("madd", 32'h0, 32'd22);
    run_op(4'd8, 32'd0, 32'd0);
    run_op(4'd7, 32'd0, 32'd0);
    run_op(4'd12, 32'd1, 32'd1);
    read_check("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    hi_m = 32'hFFFF_FFFF; lo_m = 32'hFFFF_FFFF;
`else
    run_op(4'd9, 32'd3, 32'd4);
    read_check("madd disabled", 32'h0, 32'h0);
`endif

    for (int i = 0; i < 30; i++) begin
      run_op(ops[$urandom_range(0, 11)], pick(), pick());
      read_check($sformatf("rand%0d", i), hi_m, lo_m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout checks=%0d", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
